p6_controller: RTL

//  Upstream control stage for the p6 datapath: holds the instruction register (IR), decodes the
//  16-bit instruction and sequences a Moore FSM that drives every datapath control strobe.
//  One instruction runs per start pulse; w flags idle. Supports MOV imm, MOV reg, ADD, CMP, AND, MVN.

---
 rtl/p6_isa_pkg.sv | 52 +++++
 rtl/p6_instr_dec.sv | 17 +
 rtl/p6_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/p6_isa_pkg.sv
// p6 ISA constants: opcode/op codes, ALU and writeback-mux encodings, FSM state enum.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package p6_isa_pkg;

  // Major opcodes
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Sub-ops under OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // Sub-ops under OP_ALU (the op field doubles as the ALUop)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // ALUop codes
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_AND  = 2'b10;
  localparam logic [1:0] ALUOP_NOTB = 2'b11;

  // Writeback mux select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_DECODE  = 3'd1,
    S_WR_IMM  = 3'd2,
    S_GET_A   = 3'd3,
    S_GET_B   = 3'd4,
    S_COMPUTE = 3'd5,
    S_WR_REG  = 3'd6
  } state_t;

  // Field layout of the 16-bit instruction word, MSB first
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } ir_fields_t;

endpackage

// File: rtl/p6_instr_dec.sv
// Splits the instruction register into fields and sign-extends the 5/8-bit immediates.
// Latency: purely combinational.
// Backpressure: none; follows IR continuously.
module p6_instr_dec
  import p6_isa_pkg::*;
(
  input  logic [15:0] ir,
  output ir_fields_t  fields,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  assign fields = ir_fields_t'(ir);
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/p6_controller.sv
// p6 control stage: instruction register plus Moore FSM driving the datapath strobes.
// Latency: MOV imm 3 edges, MOV reg/MVN/CMP 5, ADD/AND 6, from the s-sampling edge back to WAIT.
// Backpressure: w=0 while busy; s and load are ignored outside WAIT.
module p6_controller
  import p6_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_t     state;
  logic [15:0] ir;
  ir_fields_t f;

  logic write_raw, loada_raw, loadb_raw, loadc_raw, loads_raw, asel_raw;

  p6_instr_dec u_dec (
    .ir     (ir),
    .fields (f),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  // IR capture and state sequencing; reset aborts any instruction and clears IR
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      if (state == S_WAIT && load) ir <= in;
      case (state)
        S_WAIT:   if (s) state <= S_DECODE;
        S_DECODE: begin
          if (f.opcode == OP_MOV && f.op == MOV_IMM)
            state <= S_WR_IMM;
          else if ((f.opcode == OP_MOV && f.op == MOV_REG) ||
                   (f.opcode == OP_ALU && f.op == ALU_MVN))
            state <= S_GET_B;
          else if (f.opcode == OP_ALU)
            state <= S_GET_A;
          else
            state <= S_WAIT;
        end
        S_WR_IMM:  state <= S_WAIT;
        S_GET_A:   state <= S_GET_B;
        S_GET_B:   state <= S_COMPUTE;
        S_COMPUTE: state <= (f.opcode == OP_ALU && f.op == ALU_CMP) ? S_WAIT : S_WR_REG;
        S_WR_REG:  state <= S_WAIT;
        default:   state <= S_WAIT;
      endcase
    end
  end

  // Moore output decode from state and IR fields
  always_comb begin
    w         = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write_raw = 1'b0;
    loada_raw = 1'b0;
    loadb_raw = 1'b0;
    loadc_raw = 1'b0;
    loads_raw = 1'b0;
    asel_raw  = 1'b0;
    vsel      = VSEL_C;
    shift     = 2'b00;
    ALUop     = ALUOP_ADD;
    case (state)
      S_WAIT:  w = 1'b1;
      S_WR_IMM: begin
        writenum  = f.rn;
        vsel      = VSEL_IMM8;
        write_raw = 1'b1;
      end
      S_GET_A: begin
        readnum   = f.rn;
        loada_raw = 1'b1;
      end
      S_GET_B: begin
        readnum   = f.rm;
        loadb_raw = 1'b1;
      end
      S_COMPUTE: begin
        shift = f.sh;
        if (f.opcode == OP_MOV) begin
          asel_raw = 1'b1;
          ALUop    = ALUOP_ADD;
        end else begin
          ALUop = f.op;
        end
        if (f.opcode == OP_ALU && f.op == ALU_CMP) loads_raw = 1'b1;
        else                                       loadc_raw = 1'b1;
      end
      S_WR_REG: begin
        writenum  = f.rd;
        vsel      = VSEL_C;
        write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are held off while reset is asserted so the reset edge can never write
  assign write = write_raw & reset_n;
  assign loada = loada_raw & reset_n;
  assign loadb = loadb_raw & reset_n;
  assign loadc = loadc_raw & reset_n;
  assign loads = loads_raw & reset_n;
  assign asel  = asel_raw  & reset_n;
  assign bsel  = 1'b0;

endmodule
